execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst_n`, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port `info`, input, DecodeInfo: decoded instruction from decode; uses fields enable, funct3, alu_op, muldiv.
REQ-004 SHALL have ports `op1` and `op2`, input, 32 bits each: forwarded ALU operands.
REQ-005 SHALL have port `rs2_data`, input, 32 bits: store data.
REQ-006 SHALL have port `stall_in`, input, 1 bit: downstream hold from the pipeline controller.
REQ-007 SHALL have port `flush_in`, input, 1 bit: kill the instruction currently in execute.
REQ-008 SHALL have port `alu_out`, output, 32 bits: registered result; feeds the memory stage's addr input.
REQ-009 SHALL have port `store_data`, output, 32 bits: registered copy of rs2_data; feeds the memory stage's data input.
REQ-010 SHALL have port `info_ff`, output, DecodeInfo: registered info.
REQ-011 SHALL have port `req`, output, PipeRequest: stall_req and flush_req.

Function
REQ-012 When muldiv=0, the combinational ALU SHALL compute per alu_op: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS2 (returns op2).
REQ-013 Shift ops SHALL use op2[4:0] as the shift amount; SLT is signed; SLTU is unsigned; all arithmetic wraps modulo 2^32.
REQ-014 Non-muldiv ops SHALL have 1-cycle latency: alu_out, store_data and info_ff load on the next edge.
REQ-015 Muldiv ops SHALL use an FSM with states IDLE, MUL, DIV, DONE.
REQ-016 In IDLE with info.enable && info.muldiv, the block SHALL latch the operands and funct3, then go to:
  - MUL if funct3[2]=0;
  - DONE directly for divide-by-zero or signed overflow;
  - DIV otherwise.
REQ-017 MUL SHALL form the 64-bit product in one cycle, then go to DONE. Results:
  - MUL: low 32 bits;
  - MULH: high 32 bits, signed × signed;
  - MULHSU: high 32 bits, signed × unsigned;
  - MULHU: high 32 bits, unsigned × unsigned.
REQ-018 DIV SHALL run a restoring radix-2 divide on magnitudes for exactly 32 cycles, counted by a 5-bit counter. It then fixes signs and goes to DONE.
  - Quotient sign = sign(dividend) XOR sign(divisor).
  - Remainder sign = sign(dividend).
REQ-019 Divide by zero SHALL give DIV/DIVU = 0xFFFFFFFF and REM/REMU = dividend.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give 0x80000000; REM of the same SHALL give 0.
REQ-021 In DONE with stall_in=0, the muldiv result SHALL load into alu_out, info_ff SHALL load info, and the FSM SHALL return to IDLE.
REQ-022 req.stall_req SHALL be asserted combinationally when info.enable && info.muldiv && state != DONE.
REQ-023 Resulting stall lengths:
  - MUL*: 2 cycles;
  - DIV*/REM*: 33 cycles;
  - divide-by-zero and overflow: 1 cycle.
REQ-024 While req.stall_req=1 and stall_in=0, info_ff.enable SHALL be loaded with 0 (bubble); alu_out and store_data SHALL be don't-care.
REQ-025 While stall_in=1, alu_out, store_data and info_ff SHALL hold. The FSM SHALL keep iterating but SHALL remain in DONE until stall_in=0.
REQ-026 flush_in=1 SHALL force the FSM to IDLE, clear the counter, and load info_ff.enable=0 on the same edge.
REQ-027 flush_in SHALL take priority over stall_in and over DONE.
REQ-028 req.flush_req SHALL be constant 4'b0000.
REQ-029 info.enable=0 SHALL never start the FSM and SHALL propagate as a bubble.

Reset
REQ-030 While rst_n=0 at a rising edge, the block SHALL clear FSM state to IDLE, counter to 0, alu_out to 0, store_data to 0, info_ff to 0, and all latched operands to 0.
REQ-031 req.stall_req SHALL be 0 while rst_n=0.
REQ-032 Reset asserted mid-divide SHALL abandon the operation with no residual state.

Structure
REQ-033 The AluOp enum, the DecodeInfo fields alu_op and muldiv, and PipeRequest SHALL live in the shared common.sv package.
REQ-034 The iterative divider SHALL be a sub-module `serial_divider` with start, busy, done, quotient and remainder ports; the multiplier SHALL stay inline.

Verification
REQ-035 ADD op1=0x7FFFFFFF, op2=1 -> alu_out=0x80000000 one cycle later, stall_req never asserted.
REQ-036 DIV op1=0xFFFFFF9C (-100), op2=7 -> stall_req high for 33 cycles, alu_out=0xFFFFFFF2; REM -> 0xFFFFFFFE.
REQ-037 DIVU op2=0 -> 1-cycle stall, alu_out=0xFFFFFFFF; REMU op1=0x1234 -> 0x1234.
REQ-038 MULH op1=op2=0x80000000 -> 2-cycle stall, alu_out=0x40000000; MULHU 0xFFFFFFFF² -> 0xFFFFFFFE.
REQ-039 flush_in at divide cycle 10 -> FSM in IDLE next cycle, info_ff.enable=0; a following ADD completes normally.
REQ-040 stall_in held 5 cycles across DONE of a MUL -> outputs frozen; result appears on the first edge with stall_in=0; rst_n pulsed mid-DIV -> all outputs 0.

Source files
------------

// File: rtl/common.sv
// Shared pipeline types passed between decode, execute and the memory stage.
package common;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS2
    } AluOp;

    typedef struct packed {
        logic       enable;
        logic [2:0] funct3;
        AluOp       alu_op;
        logic       muldiv;
    } DecodeInfo;

    typedef struct packed {
        logic       stall_req;
        logic [3:0] flush_req;
    } PipeRequest;

endpackage

// File: rtl/serial_divider.sv
// Restoring radix-2 unsigned divider: one quotient bit per cycle, DATA_W cycles per divide.
module serial_divider #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] dsr;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;

    // quotient doubles as the dividend shift register
    assign shifted = {remainder, quotient[DATA_W-1]};
    assign diff    = shifted - {1'b0, dsr};
    assign done    = busy && (count == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            busy      <= 1'b0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            dsr       <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            count     <= '0;
            quotient  <= dividend;
            remainder <= '0;
            dsr       <= divisor;
        end else if (busy) begin
            if (!diff[DATA_W]) begin
                remainder <= diff[DATA_W-1:0];
                quotient  <= {quotient[DATA_W-2:0], 1'b1};
            end else begin
                remainder <= shifted[DATA_W-1:0];
                quotient  <= {quotient[DATA_W-2:0], 1'b0};
            end
            count <= count + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU plus a multi-cycle multiply/divide unit that stalls the pipe.
module execute
    import common::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  DecodeInfo   info,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] rs2_data,
    input  logic        stall_in,
    input  logic        flush_in,
    output logic [31:0] alu_out,
    output logic [31:0] store_data,
    output DecodeInfo   info_ff,
    output PipeRequest  req
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [31:0] a_lat, b_lat, md_result;
    logic [2:0]  f3_lat;
    logic        use_div;
    logic [31:0] alu_res;
    logic        stall_req;

    always_comb begin
        alu_res = '0;
        case (info.alu_op)
            ALU_ADD:   alu_res = op1 + op2;
            ALU_SUB:   alu_res = op1 - op2;
            ALU_SLL:   alu_res = op1 << op2[4:0];
            ALU_SLT:   alu_res = {31'b0, $signed(op1) < $signed(op2)};
            ALU_SLTU:  alu_res = {31'b0, op1 < op2};
            ALU_XOR:   alu_res = op1 ^ op2;
            ALU_SRL:   alu_res = op1 >> op2[4:0];
            ALU_SRA:   alu_res = $unsigned($signed(op1) >>> op2[4:0]);
            ALU_OR:    alu_res = op1 | op2;
            ALU_AND:   alu_res = op1 & op2;
            ALU_PASS2: alu_res = op2;
            default:   alu_res = '0;
        endcase
    end

    // Start decode works on the live operands; everything later uses the latched copies.
    logic        start_md, signed_div, div_zero, div_ovf, div_start;
    logic [31:0] dvd_mag, dvs_mag, special_res;

    assign start_md    = (state == S_IDLE) && info.enable && info.muldiv;
    assign signed_div  = ~info.funct3[0];
    assign div_zero    = (op2 == 32'd0);
    assign div_ovf     = signed_div && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
    assign dvd_mag     = (signed_div && op1[31]) ? -op1 : op1;
    assign dvs_mag     = (signed_div && op2[31]) ? -op2 : op2;
    assign div_start   = start_md && info.funct3[2] && !div_zero && !div_ovf;
    assign special_res = div_zero ? (info.funct3[1] ? op1 : 32'hFFFF_FFFF)
                                  : (info.funct3[1] ? 32'd0 : 32'h8000_0000);

    logic        div_busy, div_done;
    logic [31:0] div_q, div_r;

    serial_divider #(.DATA_W(32)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (flush_in),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    logic               a_signed, b_signed, q_neg, r_neg;
    logic signed [63:0] mul_a, mul_b, product;
    logic [31:0]        mul_sel, div_res, md_out;

    assign a_signed = (f3_lat[1:0] == 2'd1) || (f3_lat[1:0] == 2'd2);
    assign b_signed = (f3_lat[1:0] == 2'd1);
    assign mul_a    = {{32{a_signed & a_lat[31]}}, a_lat};
    assign mul_b    = {{32{b_signed & b_lat[31]}}, b_lat};
    assign product  = mul_a * mul_b;
    assign mul_sel  = (f3_lat[1:0] == 2'd0) ? product[31:0] : product[63:32];

    assign q_neg   = ~f3_lat[0] & (a_lat[31] ^ b_lat[31]);
    assign r_neg   = ~f3_lat[0] & a_lat[31];
    assign div_res = f3_lat[1] ? (r_neg ? -div_r : div_r) : (q_neg ? -div_q : div_q);
    assign md_out  = use_div ? div_res : md_result;

    assign stall_req = rst_n && info.enable && info.muldiv && (state != S_DONE);
    assign req       = '{stall_req: stall_req, flush_req: 4'b0000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_lat     <= '0;
            b_lat     <= '0;
            f3_lat    <= '0;
            md_result <= '0;
            use_div   <= 1'b0;
        end else if (flush_in) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start_md) begin
                    a_lat  <= op1;
                    b_lat  <= op2;
                    f3_lat <= info.funct3;
                    if (!info.funct3[2]) begin
                        use_div <= 1'b0;
                        state   <= S_MUL;
                    end else if (div_zero || div_ovf) begin
                        use_div   <= 1'b0;
                        md_result <= special_res;
                        state     <= S_DONE;
                    end else begin
                        use_div <= 1'b1;
                        state   <= S_DIV;
                    end
                end
                S_MUL: begin
                    md_result <= mul_sel;
                    state     <= S_DONE;
                end
                S_DIV:  if (div_done || !div_busy) state <= S_DONE;
                S_DONE: if (!stall_in) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage register toward memory: bubbles while stalling, frozen under stall_in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out    <= '0;
            store_data <= '0;
            info_ff    <= '0;
        end else if (flush_in) begin
            info_ff <= '0;
        end else if (!stall_in) begin
            if (stall_req) begin
                info_ff <= '0;
            end else begin
                alu_out    <= (state == S_DONE) ? md_out : alu_res;
                store_data <= rs2_data;
                info_ff    <= info;
            end
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage with a queue of expected results.
module tb_execute;
    import common::*;

    logic        clk;
    logic        rst_n;
    DecodeInfo   info;
    logic [31:0] op1, op2, rs2_data;
    logic        stall_in, flush_in;
    logic [31:0] alu_out, store_data;
    DecodeInfo   info_ff;
    PipeRequest  req;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] snap;

    execute dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .info       (info),
        .op1        (op1),
        .op2        (op2),
        .rs2_data   (rs2_data),
        .stall_in   (stall_in),
        .flush_in   (flush_in),
        .alu_out    (alu_out),
        .store_data (store_data),
        .info_ff    (info_ff),
        .req        (req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input AluOp op, input logic [2:0] f3, input logic md,
                         input logic [31:0] a, input logic [31:0] b);
        info     = '{enable: 1'b1, funct3: f3, alu_op: op, muldiv: md};
        op1      = a;
        op2      = b;
        rs2_data = a ^ b ^ 32'hA5A5_0000;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the loading edge.
    task automatic run_op(input string tag, input AluOp op, input logic [2:0] f3, input logic md,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_stall);
        int stalls;
        logic [31:0] exp_sd;
        drive(op, f3, md, a, b);
        exp_sd = a ^ b ^ 32'hA5A5_0000;
        exp_q.push_back(exp);
        stalls = 0;
        #1;
        while (req.stall_req && stalls < 100) begin
            @(posedge clk); #1;
            stalls++;
            if (stalls == 1) chk({tag, "_bubble"}, 32'(info_ff), 32'd0);
        end
        @(posedge clk); #1;
        chk({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
        chk({tag, "_out"}, alu_out, exp_q.pop_front());
        chk({tag, "_sd"}, store_data, exp_sd);
        chk({tag, "_en"}, 32'(info_ff.enable), 32'd1);
        info.enable = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        stall_in = 1'b0;
        flush_in = 1'b0;
        drive(ALU_ADD, 3'd4, 1'b1, 32'd100, 32'd7);
        #2;
        chk("rst_stall", 32'(req.stall_req), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu", alu_out, 32'd0);
        chk("rst_sd", store_data, 32'd0);
        chk("rst_info", 32'(info_ff), 32'd0);
        chk("rst_flushreq", 32'(req.flush_req), 32'd0);
        rst_n = 1'b1;
        info.enable = 1'b0;
        @(posedge clk); #1;

        run_op("add",   ALU_ADD,   3'd0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0);
        run_op("sub",   ALU_SUB,   3'd0, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0);
        run_op("sll",   ALU_SLL,   3'd1, 1'b0, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 0);
        run_op("sra",   ALU_SRA,   3'd5, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 0);
        run_op("srl",   ALU_SRL,   3'd5, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 0);
        run_op("slt",   ALU_SLT,   3'd2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0);
        run_op("sltu",  ALU_SLTU,  3'd3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
        run_op("xor",   ALU_XOR,   3'd4, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
        run_op("or",    ALU_OR,    3'd6, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 0);
        run_op("and",   ALU_AND,   3'd7, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);
        run_op("pass2", ALU_PASS2, 3'd0, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);

        run_op("mul",    ALU_ADD, 3'd0, 1'b1, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 2);
        run_op("mulh",   ALU_ADD, 3'd1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        run_op("mulhsu", ALU_ADD, 3'd2, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2);
        run_op("mulhu",  ALU_ADD, 3'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run_op("div",    ALU_ADD, 3'd4, 1'b1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 33);
        run_op("rem",    ALU_ADD, 3'd6, 1'b1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 33);
        run_op("divu0",  ALU_ADD, 3'd5, 1'b1, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        run_op("remu0",  ALU_ADD, 3'd7, 1'b1, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1);
        run_op("divovf", ALU_ADD, 3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", ALU_ADD, 3'd6, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Flush in the middle of a divide, then confirm the unit restarts cleanly.
        drive(ALU_ADD, 3'd4, 1'b1, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        flush_in = 1'b1;
        @(posedge clk); #1;
        flush_in = 1'b0;
        info.enable = 1'b0;
        chk("flush_info", 32'(info_ff), 32'd0);
        run_op("mul_after_flush", ALU_ADD, 3'd0, 1'b1, 32'd6, 32'd7, 32'd42, 2);
        run_op("add_after_flush", ALU_ADD, 3'd0, 1'b0, 32'd20, 32'd22, 32'd42, 0);

        // Downstream hold across DONE of a multiply.
        drive(ALU_ADD, 3'd0, 1'b1, 32'd3, 32'd5);
        exp_q.push_back(32'd15);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_done_stall", 32'(req.stall_req), 32'd0);
        snap = alu_out;
        stall_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_alu", alu_out, snap);
        chk("hold_info", 32'(info_ff), 32'd0);
        stall_in = 1'b0;
        @(posedge clk); #1;
        chk("hold_release_alu", alu_out, exp_q.pop_front());
        chk("hold_release_en", 32'(info_ff.enable), 32'd1);
        info.enable = 1'b0;

        // Reset in the middle of a divide.
        drive(ALU_ADD, 3'd4, 1'b1, 32'd77, 32'd5);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_alu", alu_out, 32'd0);
        chk("midrst_sd", store_data, 32'd0);
        chk("midrst_info", 32'(info_ff), 32'd0);
        chk("midrst_stall", 32'(req.stall_req), 32'd0);
        rst_n = 1'b1;
        info.enable = 1'b0;
        @(posedge clk); #1;
        run_op("divu_after_rst", ALU_ADD, 3'd5, 1'b1, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 33);
        run_op("remu_after_rst", ALU_ADD, 3'd7, 1'b1, 32'hFFFF_FFFF, 32'd10, 32'h0000_0005, 33);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
